// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch (imem) and load/store (dmem) requesters onto one memory port.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention instead of fixed dmem priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                io_imemReq_valid,
    output logic                io_imemReq_ready,
    input  logic [ADDR_W-1:0]   io_imemReq_bits_addrRequest,
    output logic                io_imemRsp_valid,
    output logic [DATA_W-1:0]   io_imemRsp_bits_dataResponse,

    input  logic                io_dmemReq_valid,
    output logic                io_dmemReq_ready,
    input  logic [ADDR_W-1:0]   io_dmemReq_bits_addrRequest,
    input  logic [DATA_W-1:0]   io_dmemReq_bits_dataRequest,
    input  logic [DATA_W/8-1:0] io_dmemReq_bits_activeByteLane,
    input  logic                io_dmemReq_bits_isWrite,
    output logic                io_dmemRsp_valid,
    output logic [DATA_W-1:0]   io_dmemRsp_bits_dataResponse,

    output logic                io_memReq_valid,
    input  logic                io_memReq_ready,
    output logic [ADDR_W-1:0]   io_memReq_bits_addrRequest,
    output logic [DATA_W-1:0]   io_memReq_bits_dataRequest,
    output logic [DATA_W/8-1:0] io_memReq_bits_activeByteLane,
    output logic                io_memReq_bits_isWrite,
    input  logic                io_memRsp_valid,
    input  logic [DATA_W-1:0]   io_memRsp_bits_dataResponse,

    output logic                io_err
);

    localparam int LANES = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [DATA_W-1:0] DEAD_DATA = DATA_W'(32'hDEADBEEF);
    localparam logic OWN_IMEM = 1'b0;
    localparam logic OWN_DMEM = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

    state_t              state_reg;
    logic                owner_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                mem_valid_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [LANES-1:0]    lanes_reg;
    logic                write_reg;
    logic                imem_rsp_valid_reg;
    logic [DATA_W-1:0]   imem_rsp_data_reg;
    logic                dmem_rsp_valid_reg;
    logic [DATA_W-1:0]   dmem_rsp_data_reg;
    logic                err_reg;
`ifdef ARB_ROUND_ROBIN_EN
    logic                last_grant_reg;
`endif

    logic                grant_imem;
    logic                grant_dmem;
    logic                timeout_hit;
    logic                deliver;
    logic [DATA_W-1:0]   rsp_data;

    always_comb begin
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        if (state_reg == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Under contention the requester that did not win last time goes first.
            if (io_dmemReq_valid && (!io_imemReq_valid || last_grant_reg == OWN_IMEM))
                grant_dmem = 1'b1;
            else if (io_imemReq_valid)
                grant_imem = 1'b1;
`else
            if (io_dmemReq_valid)
                grant_dmem = 1'b1;
            else if (io_imemReq_valid)
                grant_imem = 1'b1;
`endif
        end
    end

    // A real response in the final watchdog cycle takes precedence over the forced one.
    assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == CNT_LAST);
    assign deliver     = (state_reg == WAIT_RSP) && (io_memRsp_valid || timeout_hit);
    assign rsp_data    = io_memRsp_valid ? io_memRsp_bits_dataResponse : DEAD_DATA;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            owner_reg          <= OWN_DMEM;
            cnt_reg            <= '0;
            mem_valid_reg      <= 1'b0;
            addr_reg           <= '0;
            wdata_reg          <= '0;
            lanes_reg          <= '0;
            write_reg          <= 1'b0;
            imem_rsp_valid_reg <= 1'b0;
            imem_rsp_data_reg  <= '0;
            dmem_rsp_valid_reg <= 1'b0;
            dmem_rsp_data_reg  <= '0;
            err_reg            <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_reg     <= OWN_IMEM;
`endif
        end else begin
            imem_rsp_valid_reg <= 1'b0;
            dmem_rsp_valid_reg <= 1'b0;
            err_reg            <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_dmem) begin
                        addr_reg      <= io_dmemReq_bits_addrRequest;
                        wdata_reg     <= io_dmemReq_bits_dataRequest;
                        lanes_reg     <= io_dmemReq_bits_activeByteLane;
                        write_reg     <= io_dmemReq_bits_isWrite;
                        owner_reg     <= OWN_DMEM;
                        mem_valid_reg <= 1'b1;
                        state_reg     <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_reg <= OWN_DMEM;
`endif
                    end else if (grant_imem) begin
                        addr_reg      <= io_imemReq_bits_addrRequest;
                        wdata_reg     <= '0;
                        lanes_reg     <= '1;
                        write_reg     <= 1'b0;
                        owner_reg     <= OWN_IMEM;
                        mem_valid_reg <= 1'b1;
                        state_reg     <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_reg <= OWN_IMEM;
`endif
                    end
                end
                ISSUE: begin
                    if (io_memReq_ready) begin
                        mem_valid_reg <= 1'b0;
                        cnt_reg       <= '0;
                        state_reg     <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (deliver) begin
                        if (owner_reg == OWN_DMEM) begin
                            dmem_rsp_valid_reg <= 1'b1;
                            dmem_rsp_data_reg  <= rsp_data;
                        end else begin
                            imem_rsp_valid_reg <= 1'b1;
                            imem_rsp_data_reg  <= rsp_data;
                        end
                        err_reg   <= !io_memRsp_valid;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign io_imemReq_ready              = grant_imem;
    assign io_dmemReq_ready              = grant_dmem;
    assign io_imemRsp_valid              = imem_rsp_valid_reg;
    assign io_imemRsp_bits_dataResponse  = imem_rsp_data_reg;
    assign io_dmemRsp_valid              = dmem_rsp_valid_reg;
    assign io_dmemRsp_bits_dataResponse  = dmem_rsp_data_reg;
    assign io_memReq_valid               = mem_valid_reg;
    assign io_memReq_bits_addrRequest    = addr_reg;
    assign io_memReq_bits_dataRequest    = wdata_reg;
    assign io_memReq_bits_activeByteLane = lanes_reg;
    assign io_memReq_bits_isWrite        = write_reg;
    assign io_err                        = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=8); contention expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_imemReq_valid;
    logic        io_imemReq_ready;
    logic [31:0] io_imemReq_bits_addrRequest;
    logic        io_imemRsp_valid;
    logic [31:0] io_imemRsp_bits_dataResponse;
    logic        io_dmemReq_valid;
    logic        io_dmemReq_ready;
    logic [31:0] io_dmemReq_bits_addrRequest;
    logic [31:0] io_dmemReq_bits_dataRequest;
    logic [3:0]  io_dmemReq_bits_activeByteLane;
    logic        io_dmemReq_bits_isWrite;
    logic        io_dmemRsp_valid;
    logic [31:0] io_dmemRsp_bits_dataResponse;
    logic        io_memReq_valid;
    logic        io_memReq_ready;
    logic [31:0] io_memReq_bits_addrRequest;
    logic [31:0] io_memReq_bits_dataRequest;
    logic [3:0]  io_memReq_bits_activeByteLane;
    logic        io_memReq_bits_isWrite;
    logic        io_memRsp_valid;
    logic [31:0] io_memRsp_bits_dataResponse;
    logic        io_err;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clock                          (clock),
        .reset                          (reset),
        .io_imemReq_valid               (io_imemReq_valid),
        .io_imemReq_ready               (io_imemReq_ready),
        .io_imemReq_bits_addrRequest    (io_imemReq_bits_addrRequest),
        .io_imemRsp_valid               (io_imemRsp_valid),
        .io_imemRsp_bits_dataResponse   (io_imemRsp_bits_dataResponse),
        .io_dmemReq_valid               (io_dmemReq_valid),
        .io_dmemReq_ready               (io_dmemReq_ready),
        .io_dmemReq_bits_addrRequest    (io_dmemReq_bits_addrRequest),
        .io_dmemReq_bits_dataRequest    (io_dmemReq_bits_dataRequest),
        .io_dmemReq_bits_activeByteLane (io_dmemReq_bits_activeByteLane),
        .io_dmemReq_bits_isWrite        (io_dmemReq_bits_isWrite),
        .io_dmemRsp_valid               (io_dmemRsp_valid),
        .io_dmemRsp_bits_dataResponse   (io_dmemRsp_bits_dataResponse),
        .io_memReq_valid                (io_memReq_valid),
        .io_memReq_ready                (io_memReq_ready),
        .io_memReq_bits_addrRequest     (io_memReq_bits_addrRequest),
        .io_memReq_bits_dataRequest     (io_memReq_bits_dataRequest),
        .io_memReq_bits_activeByteLane  (io_memReq_bits_activeByteLane),
        .io_memReq_bits_isWrite         (io_memReq_bits_isWrite),
        .io_memRsp_valid                (io_memRsp_valid),
        .io_memRsp_bits_dataResponse    (io_memRsp_bits_dataResponse),
        .io_err                         (io_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_dmem;
        reset = 1'b1;
        io_imemReq_valid = 1'b0;
        io_imemReq_bits_addrRequest = '0;
        io_dmemReq_valid = 1'b0;
        io_dmemReq_bits_addrRequest = '0;
        io_dmemReq_bits_dataRequest = '0;
        io_dmemReq_bits_activeByteLane = '0;
        io_dmemReq_bits_isWrite = 1'b0;
        io_memReq_ready = 1'b0;
        io_memRsp_valid = 1'b0;
        io_memRsp_bits_dataResponse = '0;

        // Reset state
        tick();
        tick();
        chk("rst_memvalid", 32'(io_memReq_valid), 32'h0);
        chk("rst_addr", io_memReq_bits_addrRequest, 32'h0);
        chk("rst_lanes", 32'(io_memReq_bits_activeByteLane), 32'h0);
        chk("rst_irsp", 32'(io_imemRsp_valid), 32'h0);
        chk("rst_drsp", 32'(io_dmemRsp_valid), 32'h0);
        chk("rst_err", 32'(io_err), 32'h0);
        reset = 1'b0;
        tick();

        // 1. Single fetch
        io_imemReq_valid = 1'b1;
        io_imemReq_bits_addrRequest = 32'h100;
        io_memReq_ready = 1'b1;
        #1;
        chk("t1_iready", 32'(io_imemReq_ready), 32'h1);
        chk("t1_dready", 32'(io_dmemReq_ready), 32'h0);
        tick();
        io_imemReq_valid = 1'b0;
        #1;
        chk("t1_iready_off", 32'(io_imemReq_ready), 32'h0);
        chk("t1_memvalid", 32'(io_memReq_valid), 32'h1);
        chk("t1_addr", io_memReq_bits_addrRequest, 32'h100);
        chk("t1_wr", 32'(io_memReq_bits_isWrite), 32'h0);
        chk("t1_lanes", 32'(io_memReq_bits_activeByteLane), 32'hF);
        chk("t1_wdata", io_memReq_bits_dataRequest, 32'h0);
        tick();
        chk("t1_memvalid_off", 32'(io_memReq_valid), 32'h0);
        io_memRsp_valid = 1'b1;
        io_memRsp_bits_dataResponse = 32'h00000013;
        tick();
        io_memRsp_valid = 1'b0;
        chk("t1_irsp", 32'(io_imemRsp_valid), 32'h1);
        chk("t1_idata", io_imemRsp_bits_dataResponse, 32'h00000013);
        chk("t1_drsp", 32'(io_dmemRsp_valid), 32'h0);
        chk("t1_err", 32'(io_err), 32'h0);
        tick();
        chk("t1_irsp_pulse", 32'(io_imemRsp_valid), 32'h0);

        // 2. Store with backpressure
        io_dmemReq_valid = 1'b1;
        io_dmemReq_bits_addrRequest = 32'h200;
        io_dmemReq_bits_dataRequest = 32'hCAFEF00D;
        io_dmemReq_bits_activeByteLane = 4'h3;
        io_dmemReq_bits_isWrite = 1'b1;
        io_memReq_ready = 1'b0;
        #1;
        chk("t2_dready", 32'(io_dmemReq_ready), 32'h1);
        tick();
        io_dmemReq_valid = 1'b0;
        io_dmemReq_bits_dataRequest = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) io_memReq_ready = 1'b1;
            chk("t2_memvalid", 32'(io_memReq_valid), 32'h1);
            chk("t2_addr", io_memReq_bits_addrRequest, 32'h200);
            chk("t2_wdata", io_memReq_bits_dataRequest, 32'hCAFEF00D);
            chk("t2_lanes", 32'(io_memReq_bits_activeByteLane), 32'h3);
            chk("t2_wr", 32'(io_memReq_bits_isWrite), 32'h1);
            tick();
        end
        chk("t2_memvalid_off", 32'(io_memReq_valid), 32'h0);
        io_memRsp_valid = 1'b1;
        io_memRsp_bits_dataResponse = 32'h0;
        tick();
        io_memRsp_valid = 1'b0;
        chk("t2_drsp", 32'(io_dmemRsp_valid), 32'h1);
        chk("t2_irsp", 32'(io_imemRsp_valid), 32'h0);
        tick();
        chk("t2_drsp_pulse", 32'(io_dmemRsp_valid), 32'h0);

        // 3/4. Contention from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        io_imemReq_valid = 1'b1;
        io_imemReq_bits_addrRequest = 32'h300;
        io_dmemReq_valid = 1'b1;
        io_dmemReq_bits_addrRequest = 32'h400;
        io_dmemReq_bits_isWrite = 1'b0;
        io_dmemReq_bits_activeByteLane = 4'hF;
        io_memReq_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_dmem = (t % 2 == 0);
`else
            exp_dmem = 1'b1;
`endif
            #1;
            chk("t3_dready", 32'(io_dmemReq_ready), 32'(exp_dmem));
            chk("t3_iready", 32'(io_imemReq_ready), 32'(!exp_dmem));
            tick();
            chk("t3_addr", io_memReq_bits_addrRequest, exp_dmem ? 32'h400 : 32'h300);
            tick();
            io_memRsp_valid = 1'b1;
            io_memRsp_bits_dataResponse = 32'h1000 + 32'(t);
            tick();
            io_memRsp_valid = 1'b0;
            chk("t3_drsp", 32'(io_dmemRsp_valid), 32'(exp_dmem));
            chk("t3_irsp", 32'(io_imemRsp_valid), 32'(!exp_dmem));
            chk("t3_data", exp_dmem ? io_dmemRsp_bits_dataResponse : io_imemRsp_bits_dataResponse,
                32'h1000 + 32'(t));
            $display("contention txn %0d: dmem_granted=%0d", t, exp_dmem);
        end
        io_imemReq_valid = 1'b0;
        io_dmemReq_valid = 1'b0;
        tick();

        // 5. Watchdog timeout, then a late response that must be ignored
        io_dmemReq_valid = 1'b1;
        io_dmemReq_bits_addrRequest = 32'h500;
        tick();
        io_dmemReq_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t5_early_drsp", 32'(io_dmemRsp_valid), 32'h0);
            chk("t5_early_err", 32'(io_err), 32'h0);
        end
        tick();
        chk("t5_drsp", 32'(io_dmemRsp_valid), 32'h1);
        chk("t5_data", io_dmemRsp_bits_dataResponse, 32'hDEADBEEF);
        chk("t5_err", 32'(io_err), 32'h1);
        tick();
        chk("t5_err_pulse", 32'(io_err), 32'h0);
        io_memRsp_valid = 1'b1;
        io_memRsp_bits_dataResponse = 32'h12345678;
        tick();
        io_memRsp_valid = 1'b0;
        chk("t5_late_drsp", 32'(io_dmemRsp_valid), 32'h0);
        chk("t5_late_irsp", 32'(io_imemRsp_valid), 32'h0);
        chk("t5_late_err", 32'(io_err), 32'h0);

        // 5b. Response in the final watchdog cycle beats the timeout
        io_dmemReq_valid = 1'b1;
        tick();
        io_dmemReq_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        io_memRsp_valid = 1'b1;
        io_memRsp_bits_dataResponse = 32'h00000055;
        tick();
        io_memRsp_valid = 1'b0;
        chk("t5b_drsp", 32'(io_dmemRsp_valid), 32'h1);
        chk("t5b_data", io_dmemRsp_bits_dataResponse, 32'h00000055);
        chk("t5b_err", 32'(io_err), 32'h0);
        tick();

        // 6. Reset while in ISSUE
        io_imemReq_valid = 1'b1;
        io_imemReq_bits_addrRequest = 32'h600;
        io_memReq_ready = 1'b0;
        tick();
        io_imemReq_valid = 1'b0;
        chk("t6_memvalid", 32'(io_memReq_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("t6_async_memvalid", 32'(io_memReq_valid), 32'h0);
        chk("t6_async_addr", io_memReq_bits_addrRequest, 32'h0);
        tick();
        reset = 1'b0;
        io_memReq_ready = 1'b1;
        tick();
        chk("t6_idle_memvalid", 32'(io_memReq_valid), 32'h0);
        chk("t6_no_irsp", 32'(io_imemRsp_valid), 32'h0);
        io_imemReq_valid = 1'b1;
        io_imemReq_bits_addrRequest = 32'h700;
        #1;
        chk("t6_iready", 32'(io_imemReq_ready), 32'h1);
        tick();
        io_imemReq_valid = 1'b0;
        chk("t6_addr", io_memReq_bits_addrRequest, 32'h700);
        tick();
        io_memRsp_valid = 1'b1;
        io_memRsp_bits_dataResponse = 32'h00000077;
        tick();
        io_memRsp_valid = 1'b0;
        chk("t6_irsp", 32'(io_imemRsp_valid), 32'h1);
        chk("t6_idata", io_imemRsp_bits_dataResponse, 32'h00000077);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
